// File: rtl/xor_checksum_unit.sv
// Folds a stream of len WIDTH-bit words into a running XOR checksum and reports
// it (generate mode) or compares it against a latched reference (check mode).
module xor_checksum_unit #(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 16,
    localparam int LW     = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [LW-1:0]    len,
    input  logic [WIDTH-1:0] expected,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] checksum,
    output logic             parity,
    output logic             match,
    output logic             busy
);

    // Handshake: a word moves on an edge where in_valid && in_ready; the result
    // moves on an edge where out_valid && out_ready. Neither valid waits on ready.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [LW-1:0] MAX_LEN_LW = LW'(MAX_LEN);
    localparam logic [LW-1:0] ONE_LW     = LW'(1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [LW-1:0]     remaining_q, remaining_d;
    logic              mode_q, mode_d;
    logic [WIDTH-1:0]  expected_q, expected_d;
    logic [LW-1:0]     len_clamped;

    assign len_clamped = (len > MAX_LEN_LW) ? MAX_LEN_LW : len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            remaining_q <= '0;
            mode_q      <= 1'b0;
            expected_q  <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            remaining_q <= remaining_d;
            mode_q      <= mode_d;
            expected_q  <= expected_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        remaining_d = remaining_q;
        mode_d      = mode_q;
        expected_d  = expected_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d      = mode;
                    expected_d  = expected;
                    remaining_d = len_clamped;
                    acc_d       = '0;
                    state_d     = (len_clamped != '0) ? ACCUM : DONE;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_d       = acc_q ^ in_data;
                    // remaining is always >= 1 here, so this never wraps.
                    remaining_d = remaining_q - ONE_LW;
                    if (remaining_q == ONE_LW) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ACCUM);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        // acc keeps the last result after handoff, so gate it off in IDLE.
        checksum  = (state_q == IDLE) ? '0 : acc_q;
        parity    = ^checksum;
        match     = (state_q == DONE) && mode_q && (acc_q == expected_q);
    end

endmodule

// File: tb/tb_xor_checksum_unit.sv
// Directed bench for xor_checksum_unit: a vector table of complete runs plus
// hand-written sequences for bubbles, backpressure, clamping and mid-run reset.
module tb_xor_checksum_unit;

    localparam int WIDTH   = 8;
    localparam int MAX_LEN = 16;
    localparam int LW      = $clog2(MAX_LEN + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             mode = 1'b0;
    logic [LW-1:0]    len = '0;
    logic [WIDTH-1:0] expected = '0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] checksum;
    logic             parity;
    logic             match;
    logic             busy;

    int total = 0;
    int bad   = 0;

    xor_checksum_unit #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .len(len),
        .expected(expected), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .checksum(checksum), .parity(parity), .match(match), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                  mode;
        logic [LW-1:0]         len;
        logic [WIDTH-1:0]      expected;
        logic [3:0][WIDTH-1:0] words;
        logic [WIDTH-1:0]      exp_cs;
        logic                  exp_par;
        logic                  exp_match;
    } vec_t;

    vec_t vecs[10];

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b want %0b", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h want %02h", name, act, exp);
        end
    endtask

    // Drives inputs 1 time unit after the rising edge, so every check below
    // observes settled values well away from the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic m, input logic [LW-1:0] l, input logic [WIDTH-1:0] e);
        start = 1'b1; mode = m; len = l; expected = e;
        tick();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w);
        in_valid = 1'b1; in_data = w;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic handoff(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk1({name, " idle busy"}, busy, 1'b0);
        chk1({name, " idle out_valid"}, out_valid, 1'b0);
        chk8({name, " idle checksum"}, checksum, 8'h00);
    endtask

    task automatic run_vec(input int idx);
        vec_t  v;
        string nm;
        v  = vecs[idx];
        nm = $sformatf("vec%0d", idx);
        do_start(v.mode, v.len, v.expected);
        if (v.len == '0) begin
            chk1({nm, " zero-len out_valid"}, out_valid, 1'b1);
        end else begin
            chk1({nm, " in_ready after start"}, in_ready, 1'b1);
            chk1({nm, " busy after start"}, busy, 1'b1);
            for (int i = 0; i < int'(v.len); i++) begin
                send_word(v.words[i]);
                if (i == 0 && v.len > 1) begin
                    chk8({nm, " running checksum"}, checksum, v.words[0]);
                    chk1({nm, " running match"}, match, 1'b0);
                end
            end
            chk1({nm, " out_valid at edge N"}, out_valid, 1'b1);
            chk1({nm, " in_ready low in done"}, in_ready, 1'b0);
        end
        chk8({nm, " checksum"}, checksum, v.exp_cs);
        chk1({nm, " parity"}, parity, v.exp_par);
        chk1({nm, " match"}, match, v.exp_match);
        handoff(nm);
    endtask

    function automatic vec_t mk(input logic m, input logic [LW-1:0] l, input logic [WIDTH-1:0] e,
                                input logic [WIDTH-1:0] w0, input logic [WIDTH-1:0] w1,
                                input logic [WIDTH-1:0] w2, input logic [WIDTH-1:0] w3,
                                input logic [WIDTH-1:0] cs, input logic p, input logic mt);
        vec_t v;
        v.mode = m; v.len = l; v.expected = e;
        v.words[0] = w0; v.words[1] = w1; v.words[2] = w2; v.words[3] = w3;
        v.exp_cs = cs; v.exp_par = p; v.exp_match = mt;
        return v;
    endfunction

    initial begin
        int n_acc;
        int cyc;
        logic [WIDTH-1:0] exp_fold;

        //        mode len expected words                    checksum par match
        vecs[0] = mk(1'b0, 5'd3, 8'h00, 8'h0F, 8'hF0, 8'h3C, 8'h00, 8'hC3, 1'b0, 1'b0);
        vecs[1] = mk(1'b1, 5'd3, 8'hC3, 8'h0F, 8'hF0, 8'h3C, 8'h00, 8'hC3, 1'b0, 1'b1);
        vecs[2] = mk(1'b1, 5'd3, 8'hC2, 8'h0F, 8'hF0, 8'h3C, 8'h00, 8'hC3, 1'b0, 1'b0);
        vecs[3] = mk(1'b0, 5'd2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        vecs[4] = mk(1'b0, 5'd2, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 1'b1, 1'b0);
        vecs[5] = mk(1'b0, 5'd2, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1, 1'b0);
        vecs[6] = mk(1'b0, 5'd2, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        vecs[7] = mk(1'b1, 5'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        vecs[8] = mk(1'b1, 5'd0, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        vecs[9] = mk(1'b0, 5'd4, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08, 1'b1, 1'b0);

        // Reset state, checked before any clock edge.
        #1;
        chk1("reset busy", busy, 1'b0);
        chk1("reset in_ready", in_ready, 1'b0);
        chk1("reset out_valid", out_valid, 1'b0);
        chk8("reset checksum", checksum, 8'h00);
        chk1("reset parity", parity, 1'b0);
        chk1("reset match", match, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_vec(i);
        end

        // Bubbles: three idle cycles between the two words.
        do_start(1'b0, 5'd2, 8'h00);
        send_word(8'hAA);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("bubble out_valid", out_valid, 1'b0);
            chk1("bubble in_ready", in_ready, 1'b1);
            chk8("bubble checksum", checksum, 8'hAA);
        end
        send_word(8'h55);
        chk1("bubble done out_valid", out_valid, 1'b1);
        chk8("bubble checksum final", checksum, 8'hFF);
        chk1("bubble parity", parity, 1'b0);

        // Backpressure: result held while start is pulsed with a zero-length check run.
        start = 1'b1; mode = 1'b1; len = '0; expected = 8'h00;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk1("bp out_valid", out_valid, 1'b1);
            chk8("bp checksum", checksum, 8'hFF);
            chk1("bp match", match, 1'b0);
        end
        // start still high on the handoff edge: it must not launch a run.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        start = 1'b0;
        chk1("handoff busy", busy, 1'b0);
        tick();
        chk1("start-in-handoff ignored busy", busy, 1'b0);
        chk1("start-in-handoff ignored out_valid", out_valid, 1'b0);

        // Length clamp: MAX_LEN+3 requested, feed 1,2,3,... while in_ready holds.
        do_start(1'b0, LW'(MAX_LEN + 3), 8'h00);
        n_acc = 0;
        exp_fold = '0;
        cyc = 0;
        while (in_ready && cyc < 40) begin
            exp_fold = exp_fold ^ WIDTH'(n_acc + 1);
            send_word(WIDTH'(n_acc + 1));
            n_acc++;
            cyc++;
        end
        chk8("clamp transfer count", WIDTH'(n_acc), WIDTH'(MAX_LEN));
        chk1("clamp out_valid", out_valid, 1'b1);
        chk8("clamp checksum", checksum, exp_fold);
        chk8("clamp checksum const", checksum, 8'h10);
        chk1("clamp parity", parity, 1'b1);
        handoff("clamp");

        // Reset mid-run after 2 of 4 words.
        do_start(1'b0, 5'd4, 8'h00);
        send_word(8'h11);
        send_word(8'h22);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("midrst busy", busy, 1'b0);
        chk1("midrst in_ready", in_ready, 1'b0);
        chk1("midrst out_valid", out_valid, 1'b0);
        chk8("midrst checksum", checksum, 8'h00);
        tick();
        rst_n = 1'b1;
        do_start(1'b0, 5'd1, 8'h00);
        send_word(8'h81);
        chk1("post-rst out_valid", out_valid, 1'b1);
        chk8("post-rst checksum", checksum, 8'h81);
        chk1("post-rst parity", parity, 1'b0);
        handoff("post-rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
